// File: rtl/add_sched_pkg.sv
// Shared types and defaults for the round-robin shared-adder scheduler.
package add_sched_pkg;

    localparam int DEFAULT_NUM_REQ = 4;
    localparam int DEFAULT_WIDTH   = 4;
    localparam int COUNT_W         = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/add_rr_arb.sv
// Combinational round-robin picker: searches upward from last_grant+1, wrapping.
module add_rr_arb
    import add_sched_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               any
);

    int               cand_int;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant    = '0;
        index    = '0;
        any      = 1'b0;
        cand_int = 0;
        cand     = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand_int = (int'(last_grant) + off) % NUM_REQ;
            cand     = IDX_W'(cand_int);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/add_sched.sv
// Shares one WIDTH-bit adder among NUM_REQ requesters: IDLE -> EXEC -> RESP,
// with back-to-back grants out of RESP when the result is consumed.
module add_sched
    import add_sched_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int WIDTH   = DEFAULT_WIDTH,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic [IDX_W-1:0]         rsp_id,
    output logic                     busy,
    output logic [COUNT_W-1:0]       op_count
);

    state_t             state_reg;
    logic [IDX_W-1:0]   last_grant_reg;
    logic [IDX_W-1:0]   id_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               cin_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               cout_reg;
    logic [IDX_W-1:0]   rsp_id_reg;
    logic [COUNT_W-1:0] op_count_reg;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_index;
    logic               arb_any;
    logic               rsp_fire;
    logic               can_grant;
    logic               accept;
    logic [WIDTH:0]     add_result;

    add_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_reg),
        .grant      (arb_grant),
        .index      (arb_index),
        .any        (arb_any)
    );

    // A slot opens either when idle or when the held result is being consumed.
    assign rsp_fire   = (state_reg == ST_RESP) && rsp_ready;
    assign can_grant  = (state_reg == ST_IDLE) || rsp_fire;
    assign accept     = can_grant && arb_any;
    assign req_ready  = can_grant ? arb_grant : '0;
    assign add_result = {1'b0, a_reg} + {1'b0, b_reg} + {{WIDTH{1'b0}}, cin_reg};

    assign rsp_valid = (state_reg == ST_RESP);
    assign busy      = (state_reg != ST_IDLE);
    assign rsp_sum   = sum_reg;
    assign rsp_cout  = cout_reg;
    assign rsp_id    = rsp_id_reg;
    assign op_count  = op_count_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= IDX_W'(NUM_REQ - 1);
            id_reg         <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            cin_reg        <= 1'b0;
            sum_reg        <= '0;
            cout_reg       <= 1'b0;
            rsp_id_reg     <= '0;
            op_count_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) state_reg <= ST_EXEC;
                end
                ST_EXEC: begin
                    sum_reg    <= add_result[WIDTH-1:0];
                    cout_reg   <= add_result[WIDTH];
                    rsp_id_reg <= id_reg;
                    state_reg  <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_fire) begin
                        op_count_reg <= op_count_reg + COUNT_W'(1);
                        state_reg    <= accept ? ST_EXEC : ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            // Operands are snapshotted at grant so later input changes cannot leak in.
            if (accept) begin
                a_reg          <= req_a[arb_index*WIDTH +: WIDTH];
                b_reg          <= req_b[arb_index*WIDTH +: WIDTH];
                cin_reg        <= req_cin[arb_index];
                id_reg         <= arb_index;
                last_grant_reg <= arb_index;
            end
        end
    end

endmodule

// File: tb/tb_add_sched.sv
// Randomized and directed checks of add_sched against a transaction-level model.
module tb_add_sched;
    import add_sched_pkg::*;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int IW = 2;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_cin;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_sum;
    logic             rsp_cout;
    logic [IW-1:0]    rsp_id;
    logic             busy;
    logic [COUNT_W-1:0] op_count;

    add_sched #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: one operation in flight at most; its age counts clocks since grant.
    int m_last;
    bit m_busy;
    int m_age;
    int m_sum;
    int m_cout;
    int m_id;
    int m_count;
    int d_win;
    bit d_fire;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last  = N - 1;
        m_busy  = 1'b0;
        m_age   = 0;
        m_sum   = 0;
        m_cout  = 0;
        m_id    = 0;
        m_count = 0;
        d_win   = -1;
        d_fire  = 1'b0;
    endtask

    task automatic evaluate();
        bit            rsp_on;
        bit            can;
        int            c;
        logic [IW-1:0] ci;
        logic [N-1:0]  exp_ready;
        #1;
        rsp_on    = m_busy && (m_age >= 2);
        can       = !m_busy || (rsp_on && rsp_ready);
        d_win     = -1;
        exp_ready = '0;
        if (can) begin
            for (int k = 1; k <= N; k++) begin
                c  = (m_last + k) % N;
                ci = IW'(c);
                if (d_win < 0 && req_valid[ci]) d_win = c;
            end
        end
        if (d_win >= 0) begin
            ci = IW'(d_win);
            exp_ready[ci] = 1'b1;
        end
        d_fire = rsp_on && rsp_ready;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(rsp_on));
        check("busy", 32'(busy), 32'(m_busy));
        check("op_count", 32'(op_count), 32'(m_count));
        if (rsp_on) begin
            check("rsp_sum", 32'(rsp_sum), 32'(m_sum));
            check("rsp_cout", 32'(rsp_cout), 32'(m_cout));
            check("rsp_id", 32'(rsp_id), 32'(m_id));
        end
    endtask

    task automatic advance();
        int            total;
        logic [IW-1:0] ci;
        @(posedge clock);
        if (d_fire) begin
            $display("rsp id=%0d sum=%0h cout=%0d count=%0d", m_id, m_sum, m_cout, (m_count + 1) % 65536);
            m_count = (m_count + 1) % 65536;
            m_busy  = 1'b0;
        end
        if (m_busy) m_age++;
        if (d_win >= 0) begin
            ci     = IW'(d_win);
            total  = int'(req_a[d_win*W +: W]) + int'(req_b[d_win*W +: W]) + int'(req_cin[ci]);
            m_sum  = total % (1 << W);
            m_cout = total >> W;
            m_id   = d_win;
            m_last = d_win;
            m_busy = 1'b1;
            m_age  = 1;
        end
        @(negedge clock);
    endtask

    task automatic step();
        evaluate();
        advance();
    endtask

    task automatic wait_idle();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) if (m_busy) step();
        #1;
        check("idle_wait", 32'(busy), 32'(0));
        @(negedge clock);
    endtask

    initial begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;
        reset_n   = 1'b1;
        model_reset();

        // Reset values
        #2 reset_n = 1'b0;
        @(negedge clock); #1;
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_sum", 32'(rsp_sum), 32'(0));
        check("rst_rsp_cout", 32'(rsp_cout), 32'(0));
        check("rst_rsp_id", 32'(rsp_id), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_op_count", 32'(op_count), 32'(0));
        @(negedge clock);
        reset_n = 1'b1;

        // Single op 3+5 from requester 0, latency 2
        req_valid = 4'b0001;
        req_a     = {4'd0, 4'd0, 4'd0, 4'd3};
        req_b     = {4'd0, 4'd0, 4'd0, 4'd5};
        req_cin   = '0;
        evaluate();
        check("t036_grant", 32'(req_ready), 32'(4'b0001));
        advance();
        req_valid = '0;
        req_a     = '1;
        step();
        evaluate();
        check("t036_sum", 32'(rsp_sum), 32'(8));
        check("t036_cout", 32'(rsp_cout), 32'(0));
        check("t036_id", 32'(rsp_id), 32'(0));
        advance();
        evaluate();
        check("t036_count", 32'(op_count), 32'(1));
        advance();

        // All requesters continuously valid: rotation, 2 cycles per op
        req_valid = '1;
        for (int i = 0; i < 12; i++) begin
            req_a   = 16'($urandom);
            req_b   = 16'($urandom);
            req_cin = 4'($urandom);
            step();
        end
        wait_idle();

        // Overflow from requester 2
        req_valid = 4'b0100;
        req_a     = 16'h0F00;
        req_b     = 16'h0F00;
        req_cin   = 4'b0100;
        step();
        req_valid = '0;
        step();
        evaluate();
        check("t038_sum", 32'(rsp_sum), 32'(15));
        check("t038_cout", 32'(rsp_cout), 32'(1));
        check("t038_id", 32'(rsp_id), 32'(2));
        advance();
        wait_idle();

        // Consumer stalls in RESP while requester 1 waits
        req_valid = 4'b0010;
        req_a     = 16'h00A0;
        req_b     = 16'h0030;
        req_cin   = '0;
        rsp_ready = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            req_a = 16'($urandom);
            step();
        end
        rsp_ready = 1'b1;
        evaluate();
        check("t039_regrant", 32'(req_ready), 32'(4'b0010));
        advance();
        wait_idle();

        // Reset while executing discards the operation
        req_valid = 4'b1000;
        step();
        reset_n = 1'b0;
        model_reset();
        #1;
        check("t040_rsp_valid", 32'(rsp_valid), 32'(0));
        check("t040_busy", 32'(busy), 32'(0));
        check("t040_op_count", 32'(op_count), 32'(0));
        @(posedge clock); @(negedge clock); #1;
        check("t040_hold_valid", 32'(rsp_valid), 32'(0));
        @(negedge clock);
        reset_n   = 1'b1;
        req_valid = '1;
        evaluate();
        check("t040_first_grant", 32'(req_ready), 32'(4'b0001));
        advance();
        wait_idle();

        // Counter wrap
        force dut.op_count_reg = 16'hFFFF;
        #2;
        release dut.op_count_reg;
        m_count   = 16'hFFFF;
        @(negedge clock);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        step();
        step();
        evaluate();
        check("t041_wrap", 32'(op_count), 32'(0));
        advance();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            req_valid = 4'($urandom);
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
            req_cin   = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
